nd_loop_sequencer: RTL and testbench
====================================

// Module: nd_loop_sequencer
// PURPOSE
// - Walks an N-D loop nest {beg, stride, end} per dim and streams one index vector per beat.
// - Uses a valid/ack handshake at both ends.
// - Sits between the config/instruction fetch stage and the address-generation datapath; owns the N-D carry chain state.
// - dim 0 = outermost, dim DIM-1 = innermost.
// PARAMETERS
// - BW   8  width of every index/beg/stride/end element
// - DIM  2  number of loop dimensions (>=1)
// PORTS
// - i_clk          in   1         clock; single clock domain
// - i_rst          in   1         asynchronous, active-high reset
// - i_cfg_rdy      in   1         config valid
// - o_cfg_ack      out  1         config accepted (high only in IDLE)
// - i_cfg_beg      in   BW x DIM  per-dim start value
// - i_cfg_stride   in   BW x DIM  per-dim increment
// - i_cfg_end      in   BW x DIM  per-dim exclusive end (equality-terminated)
// - o_dst_rdy      out  1         index vector valid
// - i_dst_ack      in   1         consumer accepts current vector
// - o_dst_idx      out  BW x DIM  current index vector
// - o_dst_sel_ret  out  DIM+1     wrap flags of the step leaving this beat; bit k = dims >= DIM-k wrap; bit DIM = whole nest done
// - o_dst_last     out  1         == o_dst_sel_ret[DIM]
// - i_abort        in   1         only with ND_SEQ_ABORT_EN
// BEHAVIOUR
// Reset
// - state=IDLE; o_cfg_ack=1; o_dst_rdy=0.
// - o_dst_idx, o_dst_sel_ret, o_dst_last = 0; beg/stride/end regs = 0.
// Handshakes
// - Transfer on rdy&&ack, both sides.
// - o_dst_* hold stable while o_dst_rdy && !i_dst_ack.
// States
// - IDLE: cfg transfer -> latch beg/stride/end, cur=beg.
//   - If any dim has beg==end: empty nest, stay IDLE, emit nothing.
//   - Else -> RUN.
// - RUN: o_dst_rdy=1, o_cfg_ack=0.
//   - On dst transfer, step per dim i: nxt[i] = cur[i]+stride[i] (mod 2^BW).
//   - Dim i is "last" when nxt[i]==end[i].
//   - Innermost dim always steps. Dim i steps only if all dims >i are last.
//   - Stepping dims that are last reload beg. Other dims hold.
//   - If all dims are last: -> IDLE.
// Latency
// - First vector valid the cycle after cfg transfer.
// - One vector per cycle under continuous ack.
// - One bubble cycle after the last beat before the next cfg is acked. No cfg/dst overlap.
// Flags
// - o_dst_sel_ret is combinational from registered cur/stride/end; valid whenever o_dst_rdy.
// - Unreachable end (beg+k*stride never == end mod 2^BW) loops forever; caller's responsibility.
// Boundary cases
// - stride=0 with beg!=end is unreachable, treated as above.
// - DIM=1: sel_ret[0]=always 1, sel_ret[1]=last.
// - i_cfg_rdy while RUN: ignored, held off by o_cfg_ack=0.
// - i_rst mid-RUN: immediate IDLE, outputs to reset values, no partial beat.
// - All arithmetic wraps at BW bits; no saturation.
// CONFIGURATION
// - ND_SEQ_ABORT_EN defined: port i_abort present. i_abort=1 in RUN -> next cycle IDLE, o_dst_rdy=0.
//   - A dst transfer in the abort cycle still counts. i_abort in IDLE is ignored.
// - ND_SEQ_ABORT_EN undefined: no i_abort port; a nest runs only to completion or reset.
// TESTING (DIM=2, BW=8 unless noted)
// - beg{0,0} stride{1,1} end{2,3}, ack=1 -> idx (0,0)(0,1)(0,2)(1,0)(1,1)(1,2).
//   - sel_ret 001,011,...: 3b'001 on (0,0),(0,1),(1,0),(1,1); 3b'011 on (0,2); 3b'111 + last on (1,2).
//   - Then IDLE, cfg_ack=1.
// - beg{4,10} stride{2,5} end{8,20} -> (4,10)(4,15)(6,10)(6,15); last on (6,15).
// - Random ack stall (30% low) on first case -> identical sequence; idx stable during every stall.
// - beg{3,0} end{3,5} -> cfg acked, o_dst_rdy stays 0, next cfg accepted next cycle.
// - Wrap: BW=4, beg{0,14} stride{1,1} end{1,2} -> (0,14)(0,15)(0,0)(0,1); last on (0,1).
// - i_rst pulsed after beat 2 of first case -> o_dst_rdy=0 same cycle (async).
//   - After release, fresh cfg restarts at (0,0).
//   - With ND_SEQ_ABORT_EN, abort at beat 3 behaves the same but synchronously.

Source files
------------

// File: rtl/nd_loop_sequencer.sv
// nd_loop_sequencer: walks an N-D {beg, stride, end} loop nest and streams one index vector per beat.
// Define ND_SEQ_ABORT_EN to add the i_abort port (synchronous early exit from RUN).
module nd_loop_sequencer #(
   parameter int BW  = 8,
   parameter int DIM = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
`ifdef ND_SEQ_ABORT_EN
   input  logic              i_abort,
`endif
   input  logic              i_cfg_rdy,
   output logic              o_cfg_ack,
   input  logic [DIM*BW-1:0] i_cfg_beg,
   input  logic [DIM*BW-1:0] i_cfg_stride,
   input  logic [DIM*BW-1:0] i_cfg_end,
   output logic              o_dst_rdy,
   input  logic              i_dst_ack,
   output logic [DIM*BW-1:0] o_dst_idx,
   output logic [DIM:0]      o_dst_sel_ret,
   output logic              o_dst_last
);
   typedef enum logic {IDLE, RUN} state_t;
   state_t r_state;
   logic [BW-1:0] r_beg [DIM];
   logic [BW-1:0] r_stride [DIM];
   logic [BW-1:0] r_end [DIM];
   logic [BW-1:0] r_cur [DIM];
   logic [BW-1:0] w_nxt [DIM];
   logic [BW-1:0] w_step [DIM];
   logic [DIM-1:0] w_last;
   logic [DIM:0] w_sel;
   logic w_empty;
   // w_sel[k]: the innermost k dims all hit their end on this step (carry chain)
   always_comb begin
      w_empty = 1'b0;
      w_sel[0] = 1'b1;
      for (int i = 0; i < DIM; i++) begin
         w_nxt[i] = r_cur[i] + r_stride[i];
         w_last[i] = w_nxt[i] == r_end[i];
         w_empty = w_empty | (i_cfg_beg[i*BW +: BW] == i_cfg_end[i*BW +: BW]);
      end
      for (int k = 1; k <= DIM; k++) w_sel[k] = w_sel[k-1] & w_last[DIM-k];
      for (int i = 0; i < DIM; i++)
         w_step[i] = !w_sel[DIM-1-i] ? r_cur[i] : w_last[i] ? r_beg[i] : w_nxt[i];
   end
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
         for (int i = 0; i < DIM; i++) begin
            r_beg[i] <= '0;
            r_stride[i] <= '0;
            r_end[i] <= '0;
            r_cur[i] <= '0;
         end
      end else if (r_state == IDLE) begin
         if (i_cfg_rdy) begin
            for (int i = 0; i < DIM; i++) begin
               r_beg[i] <= i_cfg_beg[i*BW +: BW];
               r_stride[i] <= i_cfg_stride[i*BW +: BW];
               r_end[i] <= i_cfg_end[i*BW +: BW];
               r_cur[i] <= i_cfg_beg[i*BW +: BW];
            end
            r_state <= w_empty ? IDLE : RUN;
         end
      end else begin
         if (i_dst_ack) begin
            for (int i = 0; i < DIM; i++) r_cur[i] <= w_step[i];
            if (w_sel[DIM]) r_state <= IDLE;
         end
`ifdef ND_SEQ_ABORT_EN
         if (i_abort) r_state <= IDLE;
`endif
      end
   end
   for (genvar g = 0; g < DIM; g++) begin : g_idx
      assign o_dst_idx[g*BW +: BW] = r_cur[g];
   end
   assign o_cfg_ack = r_state == IDLE;
   assign o_dst_rdy = r_state == RUN;
   assign o_dst_sel_ret = o_dst_rdy ? w_sel : '0;
   assign o_dst_last = o_dst_sel_ret[DIM];
endmodule

// File: tb/tb_nd_loop_sequencer.sv
// tb_nd_loop_sequencer: table-driven and random nests against a nested-loop reference model.
module tb_nd_loop_sequencer;
   logic clk = 0, rst = 1;
   always #5 clk = ~clk;
   logic cfg_rdy = 0, dst_ack = 0, abort = 0;
   logic cfg_ack, dst_rdy, dst_last;
   logic [15:0] beg = 0, str = 0, en = 0, idx;
   logic [2:0] sel;
   logic cfg_rdy4 = 0, dst_ack4 = 0;
   logic cfg_ack4, dst_rdy4, dst_last4;
   logic [7:0] beg4 = 0, str4 = 0, en4 = 0, idx4;
   logic [2:0] sel4;
   int n_chk = 0, n_fail = 0;

   nd_loop_sequencer #(.BW(8), .DIM(2)) u_dut (
      .i_clk(clk), .i_rst(rst),
`ifdef ND_SEQ_ABORT_EN
      .i_abort(abort),
`endif
      .i_cfg_rdy(cfg_rdy), .o_cfg_ack(cfg_ack),
      .i_cfg_beg(beg), .i_cfg_stride(str), .i_cfg_end(en),
      .o_dst_rdy(dst_rdy), .i_dst_ack(dst_ack), .o_dst_idx(idx),
      .o_dst_sel_ret(sel), .o_dst_last(dst_last));

   nd_loop_sequencer #(.BW(4), .DIM(2)) u_dut4 (
      .i_clk(clk), .i_rst(rst),
`ifdef ND_SEQ_ABORT_EN
      .i_abort(1'b0),
`endif
      .i_cfg_rdy(cfg_rdy4), .o_cfg_ack(cfg_ack4),
      .i_cfg_beg(beg4), .i_cfg_stride(str4), .i_cfg_end(en4),
      .o_dst_rdy(dst_rdy4), .i_dst_ack(dst_ack4), .o_dst_idx(idx4),
      .o_dst_sel_ret(sel4), .o_dst_last(dst_last4));

   typedef struct {logic [7:0] a, b; logic [2:0] sel;} beat_t;
   typedef struct {logic [7:0] b0, b1, s0, s1, e0, e1; int stall; int n; logic [15:0] fin;} vec_t;
   beat_t q[$];
   vec_t tab[5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: plain nested loops, dim 0 outer, equality-terminated, 8-bit wrap
   task automatic model(input logic [7:0] b0, b1, s0, s1, e0, e1);
      logic [7:0] a, b, na, nb;
      logic il, ol;
      q.delete();
      if (b0 == e0 || b1 == e1) return;
      a = b0;
      forever begin
         b = b1;
         forever begin
            nb = b + s1;
            na = a + s0;
            il = nb == e1;
            ol = na == e0;
            q.push_back('{a, b, {il && ol, il, 1'b1}});
            if (il || q.size() > 2000) break;
            b = nb;
         end
         if (na == e0 || q.size() > 2000) break;
         a = na;
      end
   endtask

   // Called at a negedge; returns at a negedge with the DUT idle
   task automatic run(input logic [7:0] b0, b1, s0, s1, e0, e1, input int stall,
                      output int beats, output logic [15:0] fin);
      int cyc, lim;
      logic prv;
      logic [15:0] pidx;
      cyc = 0; prv = 0; pidx = '0; beats = 0; fin = '0;
      model(b0, b1, s0, s1, e0, e1);
      lim = 20 + 10 * q.size();
      chk("cfg_ack_idle", cfg_ack, 1);
      cfg_rdy = 1; beg = {b1, b0}; str = {s1, s0}; en = {e1, e0};
      dst_ack = 0;
      while (q.size() > 0 && cyc < lim) begin
         @(negedge clk);
         cyc++;
         chk("dst_rdy_run", dst_rdy, 1);
         chk("cfg_ack_run", cfg_ack, 0);
         if (prv) chk("stall_hold", idx, pidx);
         chk("idx", idx, {q[0].b, q[0].a});
         chk("sel_ret", sel, q[0].sel);
         chk("last", dst_last, q[0].sel[2]);
         dst_ack = $urandom_range(99) >= stall;
         cfg_rdy = 1'($urandom_range(1));
         beg = 16'($urandom); str = 16'($urandom); en = 16'($urandom);
         prv = !dst_ack;
         pidx = idx;
         if (dst_ack) begin
            if (dst_rdy) begin beats++; fin = idx; end
            void'(q.pop_front());
         end
      end
      if (q.size() > 0) chk("timeout", q.size(), 0);
      @(negedge clk);
      cfg_rdy = 0; dst_ack = 0;
      chk("done_rdy", dst_rdy, 0);
      chk("done_cfg_ack", cfg_ack, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int beats, k0, k1;
      logic [15:0] fin;
      logic [15:0] h_idx[6];
      logic [2:0] h_sel[6];
      logic [7:0] w_idx[4];
      logic [7:0] rb0, rb1, rs0, rs1;
      tab[0] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 0, 6, 16'h0201};
      tab[1] = '{8'd4, 8'd10, 8'd2, 8'd5, 8'd8, 8'd20, 0, 4, 16'h0F06};
      tab[2] = '{8'd3, 8'd0, 8'd1, 8'd1, 8'd3, 8'd5, 0, 0, 16'h0000};
      tab[3] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 30, 6, 16'h0201};
      tab[4] = '{8'd4, 8'd10, 8'd2, 8'd5, 8'd8, 8'd20, 30, 4, 16'h0F06};
      h_idx = '{16'h0000, 16'h0100, 16'h0200, 16'h0001, 16'h0101, 16'h0201};
      h_sel = '{3'b001, 3'b001, 3'b011, 3'b001, 3'b001, 3'b111};
      w_idx = '{8'hE0, 8'hF0, 8'h00, 8'h10};

      @(negedge clk);
      chk("rst_cfg_ack", cfg_ack, 1);
      chk("rst_dst_rdy", dst_rdy, 0);
      chk("rst_idx", idx, 0);
      chk("rst_sel", sel, 0);
      chk("rst_last", dst_last, 0);
      rst = 0;
      @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         run(tab[i].b0, tab[i].b1, tab[i].s0, tab[i].s1, tab[i].e0, tab[i].e1, tab[i].stall, beats, fin);
         chk($sformatf("tab%0d_beats", i), beats, tab[i].n);
         chk($sformatf("tab%0d_final", i), fin, tab[i].fin);
      end

      // Hand sequence: first case with continuous ack, flags spelled out
      cfg_rdy = 1; beg = 0; str = 16'h0101; en = 16'h0302; dst_ack = 1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         cfg_rdy = 0;
         chk($sformatf("h_idx%0d", i), idx, h_idx[i]);
         chk($sformatf("h_sel%0d", i), sel, h_sel[i]);
      end
      @(negedge clk);
      dst_ack = 0;
      chk("h_bubble_rdy", dst_rdy, 0);
      chk("h_bubble_cfg_ack", cfg_ack, 1);

      // Wrap at BW=4
      cfg_rdy4 = 1; beg4 = 8'hE0; str4 = 8'h11; en4 = 8'h21; dst_ack4 = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         cfg_rdy4 = 0;
         chk($sformatf("w4_idx%0d", i), idx4, w_idx[i]);
         chk($sformatf("w4_last%0d", i), dst_last4, i == 3);
      end
      @(negedge clk);
      dst_ack4 = 0;
      chk("w4_done_rdy", dst_rdy4, 0);

      // Async reset mid-nest
      cfg_rdy = 1; beg = 0; str = 16'h0101; en = 16'h0302; dst_ack = 1;
      @(negedge clk); cfg_rdy = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 1;
      #1;
      chk("arst_rdy", dst_rdy, 0);
      chk("arst_idx", idx, 0);
      chk("arst_sel", sel, 0);
      chk("arst_cfg_ack", cfg_ack, 1);
      dst_ack = 0;
      @(negedge clk);
      rst = 0;
      run(8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 0, beats, fin);
      chk("arst_restart_beats", beats, 6);

`ifdef ND_SEQ_ABORT_EN
      cfg_rdy = 1; beg = 0; str = 16'h0101; en = 16'h0302; dst_ack = 1;
      @(negedge clk); cfg_rdy = 0;
      @(negedge clk);
      @(negedge clk);
      abort = 1;
      @(negedge clk);
      abort = 0; dst_ack = 0;
      chk("abort_rdy", dst_rdy, 0);
      chk("abort_idx", idx, 16'h0001);
      run(8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 0, beats, fin);
      chk("abort_restart_beats", beats, 6);
`endif

      // Random reachable nests under random stalls
      for (int t = 0; t < 8; t++) begin
         rb0 = 8'($urandom); rb1 = 8'($urandom);
         rs0 = 8'($urandom_range(40, 1)); rs1 = 8'($urandom_range(40, 1));
         k0 = $urandom_range(4, 1); k1 = $urandom_range(4, 1);
         run(rb0, rb1, rs0, rs1, 8'(rb0 + k0 * rs0), 8'(rb1 + k1 * rs1), 30, beats, fin);
         chk($sformatf("rnd%0d_beats", t), beats, k0 * k1);
         chk($sformatf("rnd%0d_final", t), fin,
             {8'(rb1 + (k1 - 1) * rs1), 8'(rb0 + (k0 - 1) * rs0)});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
